// File: rtl/crossy_player_ctrl.sv
// Player controller: once-per-frame grid moves, hop/death timers, score, collision handling.
// Latency: all outputs update on the edge that samples frame_tick or collision; there is no backpressure.
module crossy_player_ctrl #(
  parameter int GRID_COLS    = 20,
  parameter int GRID_ROWS    = 15,
  parameter int START_COL    = 10,
  parameter int START_ROW    = 14,
  parameter int HOP_FRAMES   = 8,
  parameter int DEATH_FRAMES = 60,
  parameter int SCORE_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               collision,
  output logic [4:0]         player_col,
  output logic [3:0]         player_row,
  output logic               hopping,
  output logic [1:0]         state,
  output logic [SCORE_W-1:0] score
);

  localparam int HOP_W   = (HOP_FRAMES > 1) ? $clog2(HOP_FRAMES) : 1;
  localparam int DEATH_W = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;

  localparam logic [4:0]         COL_MAX    = 5'(GRID_COLS - 1);
  localparam logic [3:0]         ROW_MAX    = 4'(GRID_ROWS - 1);
  localparam logic [4:0]         SPAWN_COL  = 5'(START_COL);
  localparam logic [3:0]         SPAWN_ROW  = 4'(START_ROW);
  localparam logic [HOP_W-1:0]   HOP_LOAD   = HOP_W'(HOP_FRAMES - 1);
  localparam logic [DEATH_W-1:0] DEATH_LOAD = DEATH_W'(DEATH_FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_HOP  = 2'd2,
    S_DEAD = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [4:0]           col_q, col_d;
  logic [3:0]           row_q, row_d;
  logic [3:0]           best_row_q, best_row_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [HOP_W-1:0]     hop_cnt_q, hop_cnt_d;
  logic [DEATH_W-1:0]   death_cnt_q, death_cnt_d;
  logic [3:0]           prev_btn_q, prev_btn_d;
  logic                 hopping_q, hopping_d;

  logic [3:0] btn;
  logic [3:0] press;
  logic       can_move;
  logic [4:0] tgt_col;
  logic [3:0] tgt_row;

  assign btn   = {btn_up, btn_down, btn_left, btn_right};
  assign press = frame_tick ? (btn & ~prev_btn_q) : 4'b0000;

  // Only the highest-priority press is considered; if it is blocked, nothing moves.
  always_comb begin
    can_move = 1'b0;
    tgt_col  = col_q;
    tgt_row  = row_q;
    if (press[3]) begin
      can_move = (row_q != 4'd0);
      tgt_row  = row_q - 1'b1;
    end else if (press[2]) begin
      can_move = (row_q != ROW_MAX);
      tgt_row  = row_q + 1'b1;
    end else if (press[1]) begin
      can_move = (col_q != 5'd0);
      tgt_col  = col_q - 1'b1;
    end else if (press[0]) begin
      can_move = (col_q != COL_MAX);
      tgt_col  = col_q + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    best_row_d  = best_row_q;
    score_d     = score_q;
    hop_cnt_d   = hop_cnt_q;
    death_cnt_d = death_cnt_q;
    prev_btn_d  = frame_tick ? btn : prev_btn_q;

    case (state_q)
      S_IDLE: begin
        if (|press) begin
          state_d = S_PLAY;
          score_d = '0;
        end
      end
      S_PLAY: begin
        if (collision) begin
          state_d     = S_DEAD;
          death_cnt_d = DEATH_LOAD;
        end else if (frame_tick) begin
          if (row_q == 4'd0) begin
            col_d      = SPAWN_COL;
            row_d      = SPAWN_ROW;
            best_row_d = SPAWN_ROW;
          end else if (can_move) begin
            col_d     = tgt_col;
            row_d     = tgt_row;
            state_d   = S_HOP;
            hop_cnt_d = HOP_LOAD;
            if (tgt_row < best_row_q) begin
              best_row_d = tgt_row;
              if (score_q != '1) score_d = score_q + 1'b1;
            end
          end
        end
      end
      S_HOP: begin
        if (collision) begin
          state_d     = S_DEAD;
          death_cnt_d = DEATH_LOAD;
        end else if (frame_tick) begin
          if (hop_cnt_q == '0) state_d = S_PLAY;
          else                 hop_cnt_d = hop_cnt_q - 1'b1;
        end
      end
      S_DEAD: begin
        if (frame_tick) begin
          if (death_cnt_q == '0) begin
            state_d    = S_IDLE;
            col_d      = SPAWN_COL;
            row_d      = SPAWN_ROW;
            best_row_d = SPAWN_ROW;
          end else begin
            death_cnt_d = death_cnt_q - 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    hopping_d = (state_d == S_HOP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      col_q       <= SPAWN_COL;
      row_q       <= SPAWN_ROW;
      best_row_q  <= SPAWN_ROW;
      score_q     <= '0;
      hop_cnt_q   <= '0;
      death_cnt_q <= '0;
      prev_btn_q  <= 4'b1111;
      hopping_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      best_row_q  <= best_row_d;
      score_q     <= score_d;
      hop_cnt_q   <= hop_cnt_d;
      death_cnt_q <= death_cnt_d;
      prev_btn_q  <= prev_btn_d;
      hopping_q   <= hopping_d;
    end
  end

  assign player_col = col_q;
  assign player_row = row_q;
  assign hopping    = hopping_q;
  assign state      = state_q;
  assign score      = score_q;

endmodule

// File: tb/tb_crossy_player_ctrl.sv
// Bench for crossy_player_ctrl: vector table for moves/bounds/death plus hand sequences for goal wrap, saturation and reset.
module tb_crossy_player_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic       collision;
  logic [4:0] player_col;
  logic [3:0] player_row;
  logic       hopping;
  logic [1:0] state;
  logic [7:0] score;

  int n_cmp = 0;
  int n_err = 0;

  crossy_player_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .collision  (collision),
    .player_col (player_col),
    .player_row (player_row),
    .hopping    (hopping),
    .state      (state),
    .score      (score)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] btn;
    logic       tick;
    logic       coll;
    logic [4:0] col;
    logic [3:0] row;
    logic [1:0] st;
    logic [7:0] sc;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int c, input int r, input int s, input int sc);
    chk({nm, "_col"},   32'(player_col), 32'(c));
    chk({nm, "_row"},   32'(player_row), 32'(r));
    chk({nm, "_state"}, 32'(state),      32'(s));
    chk({nm, "_score"}, 32'(score),      32'(sc));
    chk({nm, "_hop"},   32'(hopping),    (s == 2) ? 32'd1 : 32'd0);
  endtask

  task automatic push(input logic [3:0] b, input logic t, input logic c,
                      input int col, input int row, input int st, input int sc);
    vec_t v;
    v.btn = b; v.tick = t; v.coll = c;
    v.col = 5'(col); v.row = 4'(row); v.st = 2'(st); v.sc = 8'(sc);
    vq.push_back(v);
  endtask

  // Successful move on the press tick, then eight cooldown ticks (the eighth returns to PLAY).
  task automatic add_hop(input logic [3:0] b, input int col, input int row, input int sc);
    push(b, 1'b1, 1'b0, col, row, 2, sc);
    for (int k = 0; k < 7; k++) push(4'b0000, 1'b1, 1'b0, col, row, 2, sc);
    push(4'b0000, 1'b1, 1'b0, col, row, 1, sc);
  endtask

  // Called at a negedge; returns at the following negedge with tick/collision cleared.
  task automatic do_tick(input logic [3:0] b, input logic c);
    {btn_up, btn_down, btn_left, btn_right} = b;
    frame_tick = 1'b1;
    collision  = c;
    @(negedge clk);
    frame_tick = 1'b0;
    collision  = 1'b0;
  endtask

  initial begin
    int exp_sc;
    reset      = 1'b1;
    frame_tick = 1'b0;
    collision  = 1'b0;
    {btn_up, btn_down, btn_left, btn_right} = 4'b1000;
    repeat (3) @(negedge clk);
    chk_all("reset", 10, 14, 0, 0);
    reset = 1'b0;

    // Held-through-reset button, release, fresh press starts play
    for (int k = 0; k < 3; k++) push(4'b1000, 1'b1, 1'b0, 10, 14, 0, 0);
    push(4'b0000, 1'b1, 1'b0, 10, 14, 0, 0);
    push(4'b1000, 1'b1, 1'b0, 10, 14, 1, 0);
    push(4'b0000, 1'b1, 1'b0, 10, 14, 1, 0);
    push(4'b1000, 1'b0, 1'b0, 10, 14, 1, 0);
    // Scoring climbs, non-scoring revisit, simultaneous up+left
    add_hop(4'b1000, 10, 13, 1);
    add_hop(4'b1000, 10, 12, 2);
    add_hop(4'b0100, 10, 13, 2);
    add_hop(4'b1000, 10, 12, 2);
    add_hop(4'b1010, 10, 11, 3);
    // Walk to the left wall, then the bottom wall
    for (int k = 1; k <= 10; k++) add_hop(4'b0010, 10 - k, 11, 3);
    push(4'b0010, 1'b1, 1'b0, 0, 11, 1, 3);
    push(4'b0000, 1'b1, 1'b0, 0, 11, 1, 3);
    for (int k = 1; k <= 3; k++) add_hop(4'b0100, 0, 11 + k, 3);
    push(4'b0100, 1'b1, 1'b0, 0, 14, 1, 3);
    // Collision on a tick during a hop wins over the pending press
    push(4'b1000, 1'b1, 1'b0, 0, 13, 2, 3);
    push(4'b0000, 1'b1, 1'b0, 0, 13, 2, 3);
    push(4'b1000, 1'b1, 1'b1, 0, 13, 3, 3);
    for (int k = 0; k < 59; k++) push(4'b0000, 1'b1, 1'(k % 2), 0, 13, 3, 3);
    push(4'b0000, 1'b1, 1'b0, 10, 14, 0, 3);
    push(4'b1000, 1'b0, 1'b1, 10, 14, 0, 3);
    push(4'b1000, 1'b1, 1'b0, 10, 14, 1, 0);
    // Collision between ticks in PLAY
    push(4'b0000, 1'b0, 1'b1, 10, 14, 3, 0);
    for (int k = 0; k < 59; k++) push(4'b0000, 1'b1, 1'b0, 10, 14, 3, 0);
    push(4'b0000, 1'b1, 1'b0, 10, 14, 0, 0);
    push(4'b1000, 1'b1, 1'b0, 10, 14, 1, 0);

    foreach (vq[i]) begin
      {btn_up, btn_down, btn_left, btn_right} = vq[i].btn;
      frame_tick = vq[i].tick;
      collision  = vq[i].coll;
      @(negedge clk);
      frame_tick = 1'b0;
      collision  = 1'b0;
      chk_all($sformatf("v%0d", i), vq[i].col, vq[i].row, vq[i].st, vq[i].sc);
    end

    // Repeated climbs to the goal; score saturates on the 19th
    for (int c = 1; c <= 19; c++) begin
      do_tick(4'b0000, 1'b0);
      for (int r = 0; r < 14; r++) begin
        do_tick(4'b1000, 1'b0);
        repeat (8) do_tick(4'b0000, 1'b0);
      end
      exp_sc = (14 * c > 255) ? 255 : 14 * c;
      chk_all($sformatf("climb%0d_top", c), 10, 0, 1, exp_sc);
      do_tick(4'b1000, 1'b0);
      chk_all($sformatf("climb%0d_wrap", c), 10, 14, 1, exp_sc);
    end

    // Reset mid-hop
    do_tick(4'b0000, 1'b0);
    do_tick(4'b1000, 1'b0);
    chk_all("pre_rst_hop", 10, 13, 2, 255);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_all("rst_hop", 10, 14, 0, 0);
    do_tick(4'b1000, 1'b0);
    chk_all("held_after_rst", 10, 14, 0, 0);

    // Reset mid-death
    do_tick(4'b0000, 1'b0);
    do_tick(4'b1000, 1'b0);
    chk_all("play_again", 10, 14, 1, 0);
    collision = 1'b1;
    @(negedge clk);
    collision = 1'b0;
    chk_all("dead_again", 10, 14, 3, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_all("rst_dead", 10, 14, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
